// File: rtl/seg_scan_if.sv
// Bus bundle between a display-value producer and the seg_scan_ctrl scanner.
// The producer side uses the master modport; the scanner uses slave.
interface seg_scan_if #(
    parameter int NDIGITS = 4
) ();
    logic                   en;
    logic                   load;
    logic [4*NDIGITS-1:0]   value_in;
    logic                   pending;
    logic [3:0]             num;
    logic [NDIGITS-1:0]     ct;
    logic                   frame_done;

    modport master (
        output en, load, value_in,
        input  pending, num, ct, frame_done
    );

    modport slave (
        input  en, load, value_in,
        output pending, num, ct, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment digit scanner with blank gaps and frame-aligned value commit.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int NDIGITS      = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    seg_scan_if.slave   bus
);
    localparam int CNT_MAX = ((SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);

    localparam logic [0:0] ST_GAP  = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NDIGITS-1:0]     ct_q, ct_d;
    logic [3:0]             num_q, num_d;
    logic                   fd_q, fd_d;
    logic                   pending_q, pending_d;
    logic [4*NDIGITS-1:0]   active_q, active_d;
    logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
    logic                   commit;

    logic [3:0]             act_digit [NDIGITS];
    logic [NDIGITS-1:0]     idx_sel;
    logic [NDIGITS-1:0]     lit_mask;
    logic [3:0]             sel_digit;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
            assign act_digit[gi] = active_q[4*gi +: 4];
            assign idx_sel[gi]   = (idx_q == IDX_W'(gi));
`ifdef SEG_SCAN_LZB_EN
            // A digit stays dark when it and everything above it is zero; digit 0 always lights.
            if (gi == 0) begin : g_lsd
                assign lit_mask[gi] = 1'b1;
            end else begin : g_upper
                assign lit_mask[gi] = |active_q[4*NDIGITS-1:4*gi];
            end
`else
            assign lit_mask[gi] = 1'b1;
`endif
        end
    endgenerate

    always_comb begin
        sel_digit = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_sel[i]) sel_digit = act_digit[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        ct_d      = ct_q;
        num_d     = num_q;
        fd_d      = 1'b0;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        commit    = 1'b0;

        if (!bus.en) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            idx_d   = '0;
            ct_d    = '1;
            commit  = pending_q;
        end else begin
            case (state_q)
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        num_d   = sel_digit;
                        ct_d    = ~(idx_sel & lit_mask);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                        ct_d    = '1;
                        // Leaving the most significant digit closes the frame.
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            fd_d   = 1'b1;
                            commit = pending_q;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end

        // Commit reads the old shadow, so a same-cycle load survives as the new pending value.
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d  = bus.value_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_GAP;
            cnt_q     <= '0;
            idx_q     <= '0;
            ct_q      <= '1;
            num_q     <= 4'd0;
            fd_q      <= 1'b0;
            pending_q <= 1'b0;
            active_q  <= '0;
            shadow_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ct_q      <= ct_d;
            num_q     <= num_d;
            fd_q      <= fd_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
        end
    end

    assign bus.ct         = ct_q;
    assign bus.num        = num_q;
    assign bus.frame_done = fd_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = ND * SLOT;
    localparam int WATCHDOG_CYCLES = 20000;

    typedef struct packed {
        logic [ND-1:0] ct;
        logic [3:0]    num;
        logic          pending;
        logic          fd;
    } exp_t;

    logic clk;
    logic tb_reset;
    seg_scan_if #(.NDIGITS(ND)) bus ();

    seg_scan_ctrl #(.NDIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .reset (tb_reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic done     = 1'b0;

    int              p         = 0;
    logic [4*ND-1:0] m_active  = '0;
    logic [4*ND-1:0] m_shadow  = '0;
    logic            m_pending = 1'b0;
    logic [3:0]      m_num     = 4'd0;
    logic [ND-1:0]   m_ct      = '1;
    logic            m_fd      = 1'b0;

    function automatic logic lit(input int d, input logic [4*ND-1:0] act);
`ifdef SEG_SCAN_LZB_EN
        return (d == 0) || ((act >> (4*d)) != 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic step(input logic r, input logic e, input logic l, input logic [4*ND-1:0] v);
        logic commit;
        int   d;
        int   off;
        @(negedge clk);
        tb_reset     = r;
        bus.en       = e;
        bus.load     = l;
        bus.value_in = v;
        cyc++;
        if (l && !r) $display("cycle=%0d load value=%h en=%0d", cyc, v, e);
        if (r) begin
            p = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
            m_num = 4'd0; m_ct = '1; m_fd = 1'b0;
        end else begin
            commit = 1'b0;
            m_fd   = 1'b0;
            if (!e) begin
                p      = 0;
                m_ct   = '1;
                commit = m_pending;
            end else begin
                p = (p + 1) % FRAME;
                if (p == 0) begin
                    m_fd   = 1'b1;
                    commit = m_pending;
                end
                d   = p / SLOT;
                off = p % SLOT;
                if (off < BC) begin
                    m_ct = '1;
                end else begin
                    if (off == BC) m_num = m_active[4*d +: 4];
                    m_ct = lit(d, m_active) ? ~(ND'(1) << d) : '1;
                end
            end
            if (commit) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (l) begin
                m_shadow  = v;
                m_pending = 1'b1;
            end
        end
        exp_q.push_back('{ct: m_ct, num: m_num, pending: m_pending, fd: m_fd});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 16'($urandom));
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k <= FRAME && p != target; k++) step(1'b0, 1'b1, 1'b0, 16'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{ct: bus.ct, num: bus.num, pending: bus.pending, fd: bus.frame_done};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d actual ct=%b num=%h pending=%b frame_done=%b required ct=%b num=%h pending=%b frame_done=%b",
                             checks, a.ct, a.num, a.pending, a.fd, e.ct, e.num, e.pending, e.fd);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (WATCHDOG_CYCLES) @(posedge clk);
        if (!done) begin
            failures++;
            $display("FAIL timeout: driver did not finish within %0d cycles", WATCHDOG_CYCLES);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin : driver
        logic r, e, l;
        tb_reset     = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = '0;

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);

        @(posedge clk);
        #2;
        checks++;
        if (bus.ct !== 4'b1111 || bus.num !== 4'd0 || bus.pending !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset state actual ct=%b num=%h pending=%b frame_done=%b required ct=1111 num=0 pending=0 frame_done=0",
                     bus.ct, bus.num, bus.pending, bus.frame_done);
        end else begin
            $display("reset state ct=%b num=%h pending=%b frame_done=%b", bus.ct, bus.num, bus.pending, bus.frame_done);
        end

        step(1'b0, 1'b1, 1'b1, 16'h1234);
        idle(2 * FRAME + 5);

        run_to(3);
        step(1'b0, 1'b1, 1'b1, 16'hAAAA);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 16'hBEEF);
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 1'b1, 16'h0C00);
        idle(2 * FRAME + 3);

        step(1'b0, 1'b1, 1'b1, 16'h5678);
        run_to(2 * SLOT + BC + 1);
        step(1'b0, 1'b0, 1'b0, 16'h1111);
        step(1'b0, 1'b0, 1'b0, 16'h2222);
        idle(FRAME + 5);

        step(1'b0, 1'b1, 1'b1, 16'h9ABC);
        run_to(SLOT + BC + 2);
        step(1'b1, 1'b1, 1'b0, 16'h3333);
        idle(FRAME + 5);

        step(1'b0, 1'b1, 1'b1, 16'h0070);
        idle(2 * FRAME + 2);
        step(1'b0, 1'b1, 1'b1, 16'h0000);
        idle(2 * FRAME + 2);
        step(1'b0, 1'b1, 1'b1, 16'h0305);
        idle(2 * FRAME + 2);

        for (int k = 0; k < 2500; k++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 39) != 0);
            l = ($urandom_range(0, 11) == 0);
            step(r, e, l, 16'($urandom));
        end
        idle(3);

        @(posedge clk);
        #2;
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
